reset_sequencer: RTL and testbench

Parametrised successor to the fixed 7-bit reset stretcher in the CPU top level. It holds NUM_DOMAINS reset outputs (core, CP0/TLB, caches, AXI bridge, and so on) for a configurable time, then releases them in staged order. At runtime it services per-domain soft-reset requests using a quiesce handshake with timeout, so that caches or write FIFOs can drain before their domain is reset.

---
 rtl/rst_seq_pkg.sv | 27 ++
 rtl/seq_timer.sv | 25 ++
 rtl/reset_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_reset_sequencer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the staged reset sequencer.
// Domain masks are zero-extended to MAX_DOMAINS before use with lowest_set_index.
package rst_seq_pkg;

    localparam int MAX_DOMAINS = 32;

    typedef enum logic [2:0] {
        HOLD,
        RELEASE,
        RUN,
        QUIESCE,
        SOFT_HOLD
    } rst_seq_state_t;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic int unsigned lowest_set_index(input logic [MAX_DOMAINS-1:0] vec);
        int unsigned idx;
        idx = 0;
        for (int i = MAX_DOMAINS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = unsigned'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Up-counter shared by the hold, stage-gap and quiesce-timeout intervals.
// expired is high during the cycle in which the count equals limit.
module seq_timer #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic [CNT_WIDTH-1:0] limit,
    output logic                 expired
);

    logic [CNT_WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CNT_WIDTH'(1);
        end
    end

    assign expired = (count_reg == limit);

endmodule

// File: rtl/reset_sequencer.sv
// Holds all domain resets after power-on, releases them in index order, then
// services per-domain soft resets with a quiesce handshake and timeout.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS     = 4,
    parameter int HOLD_CYCLES     = 128,
    parameter int STAGE_GAP       = 16,
    parameter int QUIESCE_TIMEOUT = 1024,
    localparam int DOM_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_DOMAINS-1:0] soft_req,
    input  logic [NUM_DOMAINS-1:0] quiesce_idle,
    output logic [NUM_DOMAINS-1:0] quiesce_req,
    output logic [NUM_DOMAINS-1:0] rst_out,
    output logic                   busy,
    output logic                   timeout_flag,
    output logic [DOM_W-1:0]       timeout_domain
);

    localparam int MAX_HG    = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int MAX_IVL   = (MAX_HG > QUIESCE_TIMEOUT) ? MAX_HG : QUIESCE_TIMEOUT;
    localparam int CNT_WIDTH = $clog2(MAX_IVL + 1);
    localparam logic [DOM_W-1:0] LAST_DOM = DOM_W'(NUM_DOMAINS - 1);

    if (NUM_DOMAINS < 1 || NUM_DOMAINS > MAX_DOMAINS) begin : g_chk_domains
        $error("reset_sequencer: NUM_DOMAINS must be in 1..%0d", MAX_DOMAINS);
    end
    if (HOLD_CYCLES < 1) begin : g_chk_hold
        $error("reset_sequencer: HOLD_CYCLES must be >= 1");
    end
    if (STAGE_GAP < 1) begin : g_chk_gap
        $error("reset_sequencer: STAGE_GAP must be >= 1");
    end
    if (QUIESCE_TIMEOUT < 1) begin : g_chk_timeout
        $error("reset_sequencer: QUIESCE_TIMEOUT must be >= 1");
    end

    rst_seq_state_t         state_reg, state_next;
    logic [NUM_DOMAINS-1:0] pending_reg, pending_next;
    logic [DOM_W-1:0]       cur_dom_reg, cur_dom_next;
    logic [DOM_W-1:0]       rel_idx_reg, rel_idx_next;
    logic [NUM_DOMAINS-1:0] rst_out_reg, rst_out_next;
    logic [NUM_DOMAINS-1:0] qreq_reg, qreq_next;
    logic                   busy_reg, busy_next;
    logic                   tflag_reg, tflag_next;
    logic [DOM_W-1:0]       tdom_reg, tdom_next;

    logic [NUM_DOMAINS-1:0] req_merged;
    logic [DOM_W-1:0]       sel_dom;
    logic [NUM_DOMAINS-1:0] sel_mask;
    logic                   timeout_hit;
    logic                   timer_clear;
    logic                   timer_expired;
    logic [CNT_WIDTH-1:0]   timer_limit;

    assign req_merged = pending_reg | soft_req;
    assign sel_dom    = DOM_W'(lowest_set_index(MAX_DOMAINS'(req_merged)));
    assign sel_mask   = NUM_DOMAINS'(1) << sel_dom;

    always_comb begin
        timer_limit = CNT_WIDTH'(HOLD_CYCLES - 1);
        case (state_reg)
            RELEASE: timer_limit = CNT_WIDTH'(STAGE_GAP - 1);
            QUIESCE: timer_limit = CNT_WIDTH'(QUIESCE_TIMEOUT - 1);
            default: timer_limit = CNT_WIDTH'(HOLD_CYCLES - 1);
        endcase
    end

    // Restart on every state change and on each stage step inside RELEASE.
    assign timer_clear = (state_next != state_reg) || (state_reg == RUN) ||
                         (state_reg == RELEASE && timer_expired);

    seq_timer #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .limit  (timer_limit),
        .expired(timer_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= HOLD;
            pending_reg <= '0;
            cur_dom_reg <= '0;
            rel_idx_reg <= '0;
            rst_out_reg <= '1;
            qreq_reg    <= '0;
            busy_reg    <= 1'b1;
            tflag_reg   <= 1'b0;
            tdom_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            cur_dom_reg <= cur_dom_next;
            rel_idx_reg <= rel_idx_next;
            rst_out_reg <= rst_out_next;
            qreq_reg    <= qreq_next;
            busy_reg    <= busy_next;
            tflag_reg   <= tflag_next;
            tdom_reg    <= tdom_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg;
        cur_dom_next = cur_dom_reg;
        rel_idx_next = rel_idx_reg;
        timeout_hit  = 1'b0;
        case (state_reg)
            HOLD: begin
                if (timer_expired) begin
                    if (NUM_DOMAINS == 1) begin
                        state_next = RUN;
                    end else begin
                        state_next   = RELEASE;
                        rel_idx_next = DOM_W'(1);
                    end
                end
            end
            RELEASE: begin
                if (timer_expired) begin
                    if (rel_idx_reg == LAST_DOM) begin
                        state_next = RUN;
                    end else begin
                        rel_idx_next = rel_idx_reg + DOM_W'(1);
                    end
                end
            end
            RUN: begin
                pending_next = req_merged;
                if (|req_merged) begin
                    cur_dom_next = sel_dom;
                    pending_next = req_merged & ~sel_mask;
                    state_next   = QUIESCE;
                end
            end
            QUIESCE: begin
                pending_next = req_merged;
                if (quiesce_idle[cur_dom_reg]) begin
                    state_next = SOFT_HOLD;
                end else if (timer_expired) begin
                    state_next  = SOFT_HOLD;
                    timeout_hit = 1'b1;
                end
            end
            SOFT_HOLD: begin
                pending_next = req_merged;
                if (timer_expired) begin
                    // Chain straight into the next pending domain so busy never dips.
                    if (|req_merged) begin
                        cur_dom_next = sel_dom;
                        pending_next = req_merged & ~sel_mask;
                        state_next   = QUIESCE;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            default: begin
                state_next = HOLD;
            end
        endcase
    end

    always_comb begin
        rst_out_next = rst_out_reg;
        qreq_next    = qreq_reg;
        busy_next    = (state_next != RUN);
        tflag_next   = tflag_reg | timeout_hit;
        tdom_next    = timeout_hit ? cur_dom_reg : tdom_reg;
        case (state_reg)
            HOLD: begin
                if (timer_expired) begin
                    rst_out_next[0] = 1'b0;
                end
            end
            RELEASE: begin
                if (timer_expired) begin
                    rst_out_next[rel_idx_reg] = 1'b0;
                end
            end
            RUN: begin
                if (state_next == QUIESCE) begin
                    qreq_next[cur_dom_next] = 1'b1;
                end
            end
            QUIESCE: begin
                if (state_next == SOFT_HOLD) begin
                    rst_out_next[cur_dom_reg] = 1'b1;
                end
            end
            SOFT_HOLD: begin
                if (timer_expired) begin
                    rst_out_next[cur_dom_reg] = 1'b0;
                    qreq_next[cur_dom_reg]    = 1'b0;
                    if (state_next == QUIESCE) begin
                        qreq_next[cur_dom_next] = 1'b1;
                    end
                end
            end
            default: begin
                rst_out_next = '1;
            end
        endcase
    end

    for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_dom_out
        assign rst_out[gi]     = rst_out_reg[gi];
        assign quiesce_req[gi] = qreq_reg[gi];
    end

    assign busy           = busy_reg;
    assign timeout_flag   = tflag_reg;
    assign timeout_domain = tdom_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed and random soft-reset traffic checked
// cycle by cycle against a schedule computed from the sequencing rules.
module tb_reset_sequencer;

    localparam int N      = 3;
    localparam int H      = 8;
    localparam int G      = 2;
    localparam int QT     = 5;
    localparam int MAXLEN = 320;
    localparam int RUN_START = H + (N - 1) * G;

    logic         clk;
    logic         reset;
    logic [N-1:0] soft_req;
    logic [N-1:0] quiesce_idle;
    logic [N-1:0] quiesce_req;
    logic [N-1:0] rst_out;
    logic         busy;
    logic         timeout_flag;
    logic [1:0]   timeout_domain;

    reset_sequencer #(
        .NUM_DOMAINS    (N),
        .HOLD_CYCLES    (H),
        .STAGE_GAP      (G),
        .QUIESCE_TIMEOUT(QT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .soft_req      (soft_req),
        .quiesce_idle  (quiesce_idle),
        .quiesce_req   (quiesce_req),
        .rst_out       (rst_out),
        .busy          (busy),
        .timeout_flag  (timeout_flag),
        .timeout_domain(timeout_domain)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [N-1:0] req_plan  [MAXLEN];
    logic [N-1:0] idle_plan [MAXLEN];
    logic [N-1:0] e_rst     [MAXLEN];
    logic [N-1:0] e_qreq    [MAXLEN];
    logic         e_busy    [MAXLEN];
    logic         e_tflag   [MAXLEN];
    logic [1:0]   e_tdom    [MAXLEN];
    int           lat       [N];   // idle latency per domain; >= QT means never idle

    task automatic chk(input string tag, input int c, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, c, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input int c);
        chk("rst_rst_out", c, 32'(rst_out), 32'h7);
        chk("rst_qreq", c, 32'(quiesce_req), 32'h0);
        chk("rst_busy", c, 32'(busy), 32'h1);
        chk("rst_tflag", c, 32'(timeout_flag), 32'h0);
        chk("rst_tdom", c, 32'(timeout_domain), 32'h0);
    endtask

    // Service schedule: each accepted request quiesces at the next cycle, the
    // domain reset rises one cycle after idle (or QT cycles after quiesce start
    // on timeout), stays H cycles, and the next pending domain follows at once.
    task automatic build_model(input int len);
        logic [N-1:0] pend;
        int end_c, d, qs, rise, fin;
        for (int c = 0; c < MAXLEN; c++) begin
            for (int i = 0; i < N; i++) e_rst[c][i] = (c < H + i * G);
            e_qreq[c]    = '0;
            e_busy[c]    = (c < RUN_START);
            e_tflag[c]   = 1'b0;
            e_tdom[c]    = 2'd0;
            idle_plan[c] = '0;
        end
        pend  = '0;
        end_c = 0;
        for (int c = 0; c < len; c++) begin
            if (c >= RUN_START) pend = pend | req_plan[c];
            if (c >= RUN_START && c >= end_c - 1 && pend != '0) begin
                d = 0;
                for (int i = N - 1; i >= 0; i--) if (pend[i]) d = i;
                pend[d] = 1'b0;
                qs   = c + 1;
                rise = (lat[d] < QT) ? qs + lat[d] + 1 : qs + QT;
                fin  = rise + H;
                for (int k = qs; k < fin && k < MAXLEN; k++) begin
                    e_qreq[k][d] = 1'b1;
                    e_busy[k]    = 1'b1;
                    if (k >= rise) e_rst[k][d] = 1'b1;
                    if (lat[d] < QT && k >= qs + lat[d]) idle_plan[k][d] = 1'b1;
                end
                if (lat[d] >= QT) begin
                    for (int k = rise; k < MAXLEN; k++) begin
                        e_tflag[k] = 1'b1;
                        e_tdom[k]  = 2'(d);
                    end
                end
                $display("[TB] service dom=%0d decided=%0d qstart=%0d rst_rise=%0d end=%0d timeout=%0d",
                         d, c, qs, rise, fin, (lat[d] >= QT));
                end_c = fin;
            end
        end
    endtask

    // Cycle 0 is the cycle in which reset is first driven low.
    task automatic run_epoch(input int len, input bit end_with_reset);
        for (int c = 0; c < len; c++) begin
            chk("rst_out", c, 32'(rst_out), 32'(e_rst[c]));
            chk("quiesce_req", c, 32'(quiesce_req), 32'(e_qreq[c]));
            chk("busy", c, 32'(busy), 32'(e_busy[c]));
            chk("timeout_flag", c, 32'(timeout_flag), 32'(e_tflag[c]));
            chk("timeout_domain", c, 32'(timeout_domain), 32'(e_tdom[c]));
            reset        = (end_with_reset && c == len - 1);
            soft_req     = req_plan[c];
            quiesce_idle = idle_plan[c];
            @(negedge clk);
        end
        soft_req     = '0;
        quiesce_idle = '0;
        if (end_with_reset) begin
            chk_reset_vals(len);
            @(negedge clk);
            chk_reset_vals(len + 1);
        end
    endtask

    task automatic clear_plan();
        for (int c = 0; c < MAXLEN; c++) req_plan[c] = '0;
    endtask

    initial begin
        reset        = 1'b1;
        soft_req     = '0;
        quiesce_idle = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals(-1);

        // Directed epoch: dropped request in RELEASE, idle service, timeout,
        // simultaneous pair, re-request during own service, reset mid SOFT_HOLD.
        clear_plan();
        lat[0] = QT - 1;
        lat[1] = 2;
        lat[2] = 99;
        req_plan[9]   = 3'b001;
        req_plan[20]  = 3'b010;
        req_plan[40]  = 3'b100;
        req_plan[60]  = 3'b101;
        req_plan[100] = 3'b010;
        req_plan[106] = 3'b010;
        req_plan[125] = 3'b010;
        build_model(133);
        run_epoch(133, 1'b1);

        // Random epoch, also repeating the power-on release after the reset above.
        clear_plan();
        for (int i = 0; i < N; i++) lat[i] = int'($urandom_range(0, QT + 1));
        for (int c = 0; c < 300; c++)
            req_plan[c] = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
        build_model(300);
        run_epoch(300, 1'b1);

        clear_plan();
        for (int i = 0; i < N; i++) lat[i] = int'($urandom_range(0, QT + 1));
        for (int c = 0; c < 300; c++)
            req_plan[c] = ($urandom_range(0, 6) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
        build_model(300);
        run_epoch(300, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
